// File: rtl/move_command_transmitter_if.sv
// move_command_transmitter_if: command handshake and IR drive signals of the transmitter
interface move_command_transmitter_if;
    logic        enable;
    logic [11:0] move_command;
    logic        busy;
    logic        done;
    logic        ir_out;
    logic        ir_envelope;
    modport master (output enable, move_command, input busy, done, ir_out, ir_envelope);
    modport slave  (input enable, move_command, output busy, done, ir_out, ir_envelope);
endinterface

// File: rtl/move_command_transmitter.sv
// move_command_transmitter: sends a latched 12-bit move command as repeated pulse-width-coded IR frames
module move_command_transmitter #(
    parameter int UNIT_CYCLES  = 16200,
    parameter int CARRIER_HALF = 337,
    parameter int START_UNITS  = 4,
    parameter int GAP_UNITS    = 20,
    parameter int REPEATS      = 3
) (
    input logic clock,
    input logic reset,
    move_command_transmitter_if.slave bus
);
    localparam int MAX_SG    = START_UNITS > GAP_UNITS ? START_UNITS : GAP_UNITS;
    localparam int MAX_UNITS = MAX_SG > 2 ? MAX_SG : 2;
    localparam int CW        = $clog2(UNIT_CYCLES * MAX_UNITS);
    localparam int HW        = CARRIER_HALF > 1 ? $clog2(CARRIER_HALF) : 1;
    localparam int RW        = REPEATS > 1 ? $clog2(REPEATS) : 1;

    typedef enum logic [2:0] {IDLE, START_MARK, SPACE, DATA_MARK, GAP, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, last;
    logic [HW-1:0] car_cnt, car_cnt_n;
    logic          carrier, carrier_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [RW-1:0] rep_cnt, rep_cnt_n;
    logic [11:0]   cmd_reg, cmd_reg_n;
    logic          mark_n;

    // Next state, per-state cycle counting and carrier phase; a mark entered from another state restarts the carrier high
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        rep_cnt_n = rep_cnt;
        cmd_reg_n = cmd_reg;
        car_cnt_n = '0;
        carrier_n = 1'b1;
        last = state == START_MARK ? CW'(START_UNITS * UNIT_CYCLES - 1) :
               state == GAP ? CW'(GAP_UNITS * UNIT_CYCLES - 1) :
               (state == DATA_MARK && cmd_reg[bit_idx]) ? CW'(2 * UNIT_CYCLES - 1) :
               CW'(UNIT_CYCLES - 1);
        if (state == IDLE) begin
            if (bus.enable) begin
                cmd_reg_n = bus.move_command;
                rep_cnt_n = '0;
                bit_idx_n = '0;
                cnt_n     = '0;
                state_n   = START_MARK;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (cnt != last) begin
            cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
            case (state)
                START_MARK: state_n = SPACE;
                SPACE:      state_n = DATA_MARK;
                DATA_MARK: begin
                    if (bit_idx != 4'd11) begin
                        bit_idx_n = bit_idx + 4'd1;
                        state_n   = SPACE;
                    end else begin
                        state_n = rep_cnt != RW'(REPEATS - 1) ? GAP : DONE;
                    end
                end
                GAP: begin
                    rep_cnt_n = rep_cnt + 1'b1;
                    bit_idx_n = '0;
                    state_n   = START_MARK;
                end
                default: state_n = IDLE;
            endcase
        end
        mark_n = state_n == START_MARK || state_n == DATA_MARK;
        if (mark_n && state_n == state) begin
            car_cnt_n = car_cnt == HW'(CARRIER_HALF - 1) ? '0 : car_cnt + 1'b1;
            carrier_n = car_cnt == HW'(CARRIER_HALF - 1) ? ~carrier : carrier;
        end
    end

    // State and outputs registered together so envelope and carrier stay cycle-aligned on the LED pin
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            car_cnt         <= '0;
            carrier         <= 1'b0;
            bit_idx         <= '0;
            rep_cnt         <= '0;
            cmd_reg         <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.ir_out      <= 1'b0;
            bus.ir_envelope <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            car_cnt         <= car_cnt_n;
            carrier         <= carrier_n;
            bit_idx         <= bit_idx_n;
            rep_cnt         <= rep_cnt_n;
            cmd_reg         <= cmd_reg_n;
            bus.busy        <= state_n != IDLE && state_n != DONE;
            bus.done        <= state_n == DONE;
            bus.ir_out      <= mark_n & carrier_n;
            bus.ir_envelope <= mark_n;
        end
    end
endmodule

// File: tb/tb_move_command_transmitter.sv
// tb_move_command_transmitter: directed frame checks on single-repeat and double-repeat transmitters
module tb_move_command_transmitter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int runs[$];
    int expr[$];
    int dl[12];
    int busy_cnt, done_cnt, done_at, car_err;

    move_command_transmitter_if if0 ();
    move_command_transmitter_if if1 ();

    move_command_transmitter #(.UNIT_CYCLES(4), .CARRIER_HALF(2), .START_UNITS(4), .GAP_UNITS(2), .REPEATS(1))
        dut0 (.clock(clk), .reset(reset), .bus(if0));
    move_command_transmitter #(.UNIT_CYCLES(4), .CARRIER_HALF(2), .START_UNITS(4), .GAP_UNITS(2), .REPEATS(2))
        dut1 (.clock(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic start(input bit sel, input logic [11:0] cmd);
        @(negedge clk);
        if (sel) begin
            if1.enable = 1'b1;
            if1.move_command = cmd;
        end else begin
            if0.enable = 1'b1;
            if0.move_command = cmd;
        end
    endtask

    task automatic watch(input bit sel, input int n, input int inj);
        int cur;
        int k;
        logic e, o, b, d;
        runs.delete();
        busy_cnt = 0;
        done_cnt = 0;
        done_at = 0;
        car_err = 0;
        cur = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            e = sel ? if1.ir_envelope : if0.ir_envelope;
            o = sel ? if1.ir_out : if0.ir_out;
            b = sel ? if1.busy : if0.busy;
            d = sel ? if1.done : if0.done;
            if (b === 1'b1) begin
                busy_cnt++;
                if (e === 1'b1) begin
                    if (cur < 0) begin
                        runs.push_back(cur);
                        cur = 0;
                    end
                    k = cur;
                    cur++;
                    if (o !== (((k / 2) % 2) == 0)) car_err++;
                end else begin
                    if (cur > 0) begin
                        runs.push_back(cur);
                        cur = 0;
                    end
                    cur--;
                end
            end
            if (e !== 1'b1 && o !== 1'b0) car_err++;
            if (d === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = i;
            end
            if (i == 1) begin
                if (sel) if1.enable = 1'b0;
                else if0.enable = 1'b0;
            end
            if (inj != 0 && i == inj) begin
                if0.enable = 1'b1;
                if0.move_command = 12'hFFE;
            end
            if (inj != 0 && i == inj + 1) if0.enable = 1'b0;
        end
        if (cur != 0) runs.push_back(cur);
    endtask

    task automatic build(input int frames);
        expr.delete();
        for (int f = 0; f < frames; f++) begin
            if (f > 0) expr.push_back(-8);
            expr.push_back(16);
            for (int j = 0; j < 12; j++) begin
                expr.push_back(-4);
                expr.push_back(dl[j]);
            end
        end
    endtask

    task automatic frame_checks(input string tag, input int busy_exp, input int done_exp);
        int diffs;
        diffs = 0;
        for (int j = 0; j < runs.size() && j < expr.size(); j++)
            if (runs[j] != expr[j]) diffs++;
        check({tag, " run count"}, runs.size(), expr.size());
        check({tag, " run length diffs"}, diffs, 0);
        check({tag, " busy cycles"}, busy_cnt, busy_exp);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " done cycle"}, done_at, done_exp);
        check({tag, " carrier errors"}, car_err, 0);
    endtask

    initial begin
        if0.enable = 1'b0;
        if0.move_command = 12'h000;
        if1.enable = 1'b0;
        if1.move_command = 12'h000;
        repeat (3) @(negedge clk);
        check("reset busy", int'(if0.busy), 0);
        check("reset done", int'(if0.done), 0);
        check("reset ir_out", int'(if0.ir_out), 0);
        check("reset envelope", int'(if0.ir_envelope), 0);
        check("reset busy r2", int'(if1.busy), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle busy", int'(if0.busy), 0);

        dl = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        build(1);
        start(1'b0, 12'h000);
        watch(1'b0, 120, 0);
        frame_checks("zero", 112, 113);

        dl = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
        build(1);
        start(1'b0, 12'hFFF);
        watch(1'b0, 170, 0);
        frame_checks("ones", 160, 161);

        dl = '{4, 4, 8, 8, 8, 4, 8, 4, 4, 8, 4, 8};
        build(1);
        start(1'b0, 12'hA5C);
        watch(1'b0, 145, 0);
        frame_checks("a5c", 136, 137);

        dl = '{8, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        build(1);
        start(1'b0, 12'h001);
        watch(1'b0, 125, 30);
        frame_checks("ignored", 116, 117);
        check("ignored idle after", int'(if0.busy), 0);

        start(1'b0, 12'h000);
        repeat (112) @(negedge clk);
        @(negedge clk);
        check("held done", int'(if0.done), 1);
        check("held done busy", int'(if0.busy), 0);
        @(negedge clk);
        check("held idle busy", int'(if0.busy), 0);
        check("held idle done", int'(if0.done), 0);
        @(negedge clk);
        check("held restart busy", int'(if0.busy), 1);
        check("held restart envelope", int'(if0.ir_envelope), 1);
        check("held restart ir_out", int'(if0.ir_out), 1);

        reset = 1'b1;
        if0.enable = 1'b0;
        @(negedge clk);
        check("midreset busy", int'(if0.busy), 0);
        check("midreset ir_out", int'(if0.ir_out), 0);
        check("midreset envelope", int'(if0.ir_envelope), 0);
        check("midreset done", int'(if0.done), 0);
        reset = 1'b0;

        dl = '{8, 8, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        build(1);
        start(1'b0, 12'h003);
        watch(1'b0, 130, 0);
        frame_checks("after reset", 120, 121);

        dl = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        build(2);
        start(1'b1, 12'h000);
        watch(1'b1, 245, 0);
        frame_checks("repeats", 232, 233);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
